// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID and ID/EX front end: load-use stall,
// multi-cycle EX hold, taken-branch flush. Optional perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_mc,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        br_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mc_busy,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu;

    assign lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!br_taken && !lu && id_mc) begin
                        state <= MC_WAIT;
                        cnt   <= CNT_W'(MC_LAT - 2);
                    end
                end
                MC_WAIT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Controls are gated by rst_n so they read 0 during reset whatever the inputs.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mc_busy     = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (br_taken) begin
                        ifid_flush = 1'b1;
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    mc_busy     = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (pc_stall && (perf_stall != '1))   perf_stall <= perf_stall + 32'd1;
            if (ifid_flush && (perf_flush != '1)) perf_flush <= perf_flush + 32'd1;
        end
    end
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan sequences then random
// stimulus, checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_mc, ex_memread, br_taken;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, mc_busy;
    logic [31:0] perf_stall, perf_flush;

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mc(id_mc),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mc_busy(mc_busy),
        .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    typedef struct {
        logic [4:0]  ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_bubble, mc_busy}
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned hold_left = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    bit          stim_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: apply inputs just after the edge, predict this cycle's outputs, push.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mc, input logic mr,
                        input logic [4:0] ert, input logic br);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mc = mc;
        ex_memread = mr; ex_rt = ert; br_taken = br;
        hz = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        e.ctl = 5'b00000;
        if (!rst) begin
            hold_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else if (hold_left > 0) begin
            e.ctl = 5'b11011;
            hold_left--;
        end else if (br) begin
            e.ctl = 5'b00100;
        end else if (hz) begin
            e.ctl = 5'b11010;
        end else if (mc) begin
            hold_left = MC_LAT - 1;
        end
`ifdef HAZARD_PERF_EN
        e.ps = m_stall;
        e.pf = m_flush;
`else
        e.ps = 32'h0;
        e.pf = 32'h0;
`endif
        if (rst) begin
            if (e.ctl[4] && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (e.ctl[2] && m_flush != 32'hFFFF_FFFF) m_flush++;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle presents an output; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({pc_stall, ifid_stall, ifid_flush, idex_bubble, mc_busy} !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl t=%0t got=%b exp=%b", $time,
                             {pc_stall, ifid_stall, ifid_flush, idex_bubble, mc_busy}, e.ctl);
                end
                checks++;
                if (perf_stall !== e.ps || perf_flush !== e.pf) begin
                    failures++;
                    $display("FAIL perf t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                             perf_stall, perf_flush, e.ps, e.pf);
                end
            end
        end
    end

    initial begin
        rst_n = 0; id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rt = 0; id_mc = 0; ex_memread = 0; br_taken = 0;
        // reset with a load-use pattern applied
        for (int i = 0; i < 3; i++) step(0, 5, 0, 0, 0, 1, 5, 0);
        idle(3);
        // load-use: one cycle, then ex_rt=0, then rt match without id_uses_rt
        step(1, 5, 0, 0, 0, 1, 5, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 5, 0, 0, 1, 5, 0);
        step(1, 1, 5, 1, 0, 1, 5, 0);
        idle(2);
        // multi-cycle pulse, then held id_mc for two periods
        step(1, 0, 0, 0, 1, 0, 0, 0);
        idle(4);
        for (int i = 0; i < 2 * MC_LAT; i++) step(1, 0, 0, 0, 1, 0, 0, 0);
        idle(4);
        // branch + lu, then lu + id_mc followed by id_mc issue
        step(1, 7, 0, 0, 0, 1, 7, 1);
        step(1, 7, 0, 0, 1, 1, 7, 0);
        step(1, 7, 0, 0, 1, 0, 7, 0);
        idle(4);
        // reset on 2nd MC_WAIT cycle
        step(1, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // perf scenario: 1 lu, 1 mc op, 2 flushes
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // random phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 5) == 0),
                 1'($urandom), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0));
        end
        idle(2);
        stim_done = 1;
    end

    initial begin
        wait (stim_done);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t exp=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
